// File: rtl/aes_inv_round_ctrl.sv
// -----------------------------------------------------------------------------
// aes_inv_round_ctrl
//
// Iterative AES decryption engine. One inverse round is performed per accepted
// round key through a single shared round datapath:
//   INIT  : state ^= rk[NR]
//   ROUND : state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk[r])
//   FINAL : out   = InvSubBytes(InvShiftRows(state)) ^ rk[0]
// Round keys are fetched from an external key store by index (rk_req/rk_idx,
// answered by rk_valid/rk_data). While a key is requested but not valid,
// nothing changes and rk_idx stays put.
//
// Byte order: bits [127:120] are byte 0 (row 0, col 0); bytes run
// column-major as in FIPS-197.
//
// Parameters:
//   NK        key length in 32-bit words (4/6/8); NR = NK + 6
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   abort     (only with AES_INV_ABORT_EN) drop the block in flight
//   in_valid  ciphertext present
//   in_ready  engine idle, can accept ciphertext
//   in_data   ciphertext block
//   rk_req    round key requested
//   rk_idx    requested round-key index (NR..0)
//   rk_valid  rk_data is valid for rk_idx
//   rk_data   round key
//   out_valid plaintext valid
//   out_ready consumer accepts plaintext
//   out_data  plaintext (holds its last value until the next block finishes)
//   busy      engine not idle
//
// Optional feature macro: AES_INV_ABORT_EN (adds the abort input).
// -----------------------------------------------------------------------------
module aes_inv_round_ctrl #(
    parameter int NK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
`ifdef AES_INV_ABORT_EN
    input  logic         abort,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         rk_req,
    output logic [3:0]   rk_idx,
    input  logic         rk_valid,
    input  logic [127:0] rk_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam logic [3:0] NR = 4'(NK + 6);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } fsm_t;

    fsm_t         fsm_reg, fsm_next;
    logic [127:0] blk_reg, blk_next;
    logic [127:0] out_reg, out_next;
    logic [3:0]   round_reg, round_next;

    // ---------------- GF(2^8) helpers ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 (x^2 * x^4 * ... * x^128); maps 0 to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    // Inverse S-box: undo the affine map (rotl 1/3/6, xor 0x05), then invert.
    function automatic logic [7:0] inv_sbox(input logic [7:0] x);
        logic [7:0] y;
        y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    function automatic logic [7:0] mul09(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ a;
    endfunction
    function automatic logic [7:0] mul0b(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(a) ^ a;
    endfunction
    function automatic logic [7:0] mul0d(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ a;
    endfunction
    function automatic logic [7:0] mul0e(input logic [7:0] a);
        return xtime(xtime(xtime(a))) ^ xtime(xtime(a)) ^ xtime(a);
    endfunction

    // ---------------- shared round datapath ----------------
    logic [127:0] isr;   // InvShiftRows(state)
    logic [127:0] isb;   // InvSubBytes(isr)
    logic [127:0] ark;   // isb ^ round key (also the final-round result)
    logic [127:0] imc;   // InvMixColumns(ark)

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_byte
            localparam int ROW = gi % 4;
            localparam int COL = gi / 4;
            // Row r is rotated right by r columns.
            localparam int SRC = 4 * ((COL - ROW + 4) % 4) + ROW;
            assign isr[127-8*gi -: 8] = blk_reg[127-8*SRC -: 8];
            assign isb[127-8*gi -: 8] = inv_sbox(isr[127-8*gi -: 8]);
        end
    endgenerate

    assign ark = isb ^ rk_data;

    generate
        for (gi = 0; gi < 4; gi++) begin : g_col
            logic [7:0] a0, a1, a2, a3;
            assign a0 = ark[127-32*gi -: 8];
            assign a1 = ark[119-32*gi -: 8];
            assign a2 = ark[111-32*gi -: 8];
            assign a3 = ark[103-32*gi -: 8];
            assign imc[127-32*gi -: 8] = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
            assign imc[119-32*gi -: 8] = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
            assign imc[111-32*gi -: 8] = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
            assign imc[103-32*gi -: 8] = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);
        end
    endgenerate

    // ---------------- control ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_reg   <= IDLE;
            blk_reg   <= '0;
            out_reg   <= '0;
            round_reg <= '0;
        end else begin
            fsm_reg   <= fsm_next;
            blk_reg   <= blk_next;
            out_reg   <= out_next;
            round_reg <= round_next;
        end
    end

    always_comb begin
        fsm_next   = fsm_reg;
        blk_next   = blk_reg;
        out_next   = out_reg;
        round_next = round_reg;
        case (fsm_reg)
            IDLE: begin
                if (in_valid) begin
                    blk_next   = in_data;
                    round_next = NR;
                    fsm_next   = INIT;
                end
            end
            INIT: begin
                if (rk_valid) begin
                    blk_next   = blk_reg ^ rk_data;
                    round_next = NR - 4'd1;
                    fsm_next   = ROUND;
                end
            end
            ROUND: begin
                if (rk_valid) begin
                    blk_next = imc;
                    if (round_reg == 4'd1) begin
                        round_next = 4'd0;
                        fsm_next   = FINAL;
                    end else begin
                        round_next = round_reg - 4'd1;
                    end
                end
            end
            FINAL: begin
                if (rk_valid) begin
                    out_next = ark;
                    fsm_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) fsm_next = IDLE;
            end
            default: fsm_next = IDLE;
        endcase
`ifdef AES_INV_ABORT_EN
        // Abort wins over a key arriving in the same cycle.
        if (abort && (fsm_reg == INIT || fsm_reg == ROUND || fsm_reg == FINAL)) begin
            fsm_next   = IDLE;
            blk_next   = '0;
            round_next = '0;
            out_next   = out_reg;
        end
`endif
    end

    always_comb begin
        rk_req = 1'b0;
        rk_idx = 4'd0;
        case (fsm_reg)
            INIT:    begin rk_req = 1'b1; rk_idx = NR;        end
            ROUND:   begin rk_req = 1'b1; rk_idx = round_reg; end
            FINAL:   begin rk_req = 1'b1; rk_idx = 4'd0;      end
            default: begin rk_req = 1'b0; rk_idx = 4'd0;      end
        endcase
    end

    assign in_ready  = (fsm_reg == IDLE);
    assign busy      = (fsm_reg != IDLE);
    assign out_valid = (fsm_reg == DONE);
    assign out_data  = out_reg;

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for aes_inv_round_ctrl. Three engines (NK = 4, 6, 8) share clock
// and reset. A key store per engine answers rk_idx from round keys expanded
// in the bench. A transaction-level model (keys counted per block, plaintext
// from a byte-array AES decryption) is compared with every engine on every
// falling edge; directed FIPS-197 vectors pin latency and plaintext literally.
// -----------------------------------------------------------------------------
module tb_aes_inv_round_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         in_valid_s  [3];
    logic         in_ready_s  [3];
    logic [127:0] in_data_s   [3];
    logic         rk_req_s    [3];
    logic [3:0]   rk_idx_s    [3];
    logic         rk_valid_s  [3];
    logic [127:0] rk_data_s   [3];
    logic         out_valid_s [3];
    logic         out_ready_s [3];
    logic [127:0] out_data_s  [3];
    logic         busy_s      [3];
`ifdef AES_INV_ABORT_EN
    logic         abort_s     [3];
`endif

    logic [127:0] rk_tab [3][16];
    logic [7:0]   sbox   [256];
    logic [7:0]   inv_sb [256];
    logic [127:0] junk;

    int n_checks = 0;
    int n_err    = 0;

    // model state
    bit           m_active [3];
    bit           m_pend   [3];
    int           m_keys   [3];
    int           m_done   [3];
    logic [127:0] m_last   [3];
    logic [127:0] m_ct     [3];
    int           nr_c;

    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    localparam logic [127:0] CT8 = 128'h8ea2b7ca516745bfeafc49904b496089;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dut
            aes_inv_round_ctrl #(.NK(4 + 2 * gi)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
`ifdef AES_INV_ABORT_EN
                .abort     (abort_s[gi]),
`endif
                .in_valid  (in_valid_s[gi]),
                .in_ready  (in_ready_s[gi]),
                .in_data   (in_data_s[gi]),
                .rk_req    (rk_req_s[gi]),
                .rk_idx    (rk_idx_s[gi]),
                .rk_valid  (rk_valid_s[gi]),
                .rk_data   (rk_data_s[gi]),
                .out_valid (out_valid_s[gi]),
                .out_ready (out_ready_s[gi]),
                .out_data  (out_data_s[gi]),
                .busy      (busy_s[gi])
            );
            // Key store: garbage whenever the key is not marked valid.
            assign rk_data_s[gi] = rk_valid_s[gi] ? rk_tab[gi][rk_idx_s[gi]] : junk;
        end
    endgenerate

    always @(posedge clk) junk <= {$urandom, $urandom, $urandom, $urandom};

    // ---------------- reference AES ----------------
    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa;
        p = 0; aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sbox[x]   = s;
            inv_sb[s] = 8'(x);
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    task automatic expand(input int k, input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk, nr;
        nk = 4 + 2 * k; nr = nk + 6; rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32 * i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = w[i - 1];
            if (i % nk == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xt(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i - nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk_tab[k][r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    function automatic logic [127:0] aes_dec(input int k, input logic [127:0] ct);
        logic [7:0] s [16];
        logic [7:0] t [16];
        logic [7:0] coef [4];
        logic [7:0] acc;
        logic [127:0] key, res;
        int nr;
        coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        nr  = 10 + 2 * k;
        key = rk_tab[k][nr];
        for (int i = 0; i < 16; i++) s[i] = ct[127 - 8 * i -: 8] ^ key[127 - 8 * i -: 8];
        for (int r = nr - 1; r >= 0; r--) begin
            key = rk_tab[k][r];
            for (int c = 0; c < 4; c++)
                for (int row = 0; row < 4; row++)
                    t[4 * c + row] = inv_sb[s[4 * ((c - row + 4) % 4) + row]] ^ key[127 - 8 * (4 * c + row) -: 8];
            if (r > 0) begin
                for (int c = 0; c < 4; c++)
                    for (int row = 0; row < 4; row++) begin
                        acc = 8'h00;
                        for (int j = 0; j < 4; j++) acc ^= gmul(coef[(j - row + 4) % 4], t[4 * c + j]);
                        s[4 * c + row] = acc;
                    end
            end else begin
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
        end
        for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input int k, input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (nk=%0d) actual=%h required=%h", nm, 4 + 2 * k, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            nr_c = 10 + 2 * k;
            if (!rst_n) begin
                chk(k, "rst_in_ready",  in_ready_s[k],  1);
                chk(k, "rst_rk_req",    rk_req_s[k],    0);
                chk(k, "rst_rk_idx",    rk_idx_s[k],    0);
                chk(k, "rst_out_valid", out_valid_s[k], 0);
                chk(k, "rst_out_data",  out_data_s[k],  0);
                chk(k, "rst_busy",      busy_s[k],      0);
                m_active[k] = 0; m_pend[k] = 0; m_keys[k] = 0; m_last[k] = '0;
            end else begin
                chk(k, "busy",      busy_s[k],      m_active[k] || m_pend[k]);
                chk(k, "in_ready",  in_ready_s[k],  !(m_active[k] || m_pend[k]));
                chk(k, "rk_req",    rk_req_s[k],    m_active[k]);
                chk(k, "out_valid", out_valid_s[k], m_pend[k]);
                chk(k, "out_data",  out_data_s[k],  m_last[k]);
                if (m_active[k]) chk(k, "rk_idx", rk_idx_s[k], nr_c - m_keys[k]);
`ifdef AES_INV_ABORT_EN
                if (abort_s[k] && m_active[k]) begin
                    m_active[k] = 0; m_keys[k] = 0;
                end else
`endif
                if (m_active[k]) begin
                    if (rk_valid_s[k]) begin
                        m_keys[k]++;
                        if (m_keys[k] == nr_c + 1) begin
                            m_active[k] = 0;
                            m_pend[k]   = 1;
                            m_last[k]   = aes_dec(k, m_ct[k]);
                        end
                    end
                end else if (m_pend[k]) begin
                    if (out_ready_s[k]) begin
                        m_pend[k] = 0;
                        m_done[k]++;
                    end
                end else if (in_valid_s[k]) begin
                    m_active[k] = 1;
                    m_keys[k]   = 0;
                    m_ct[k]     = in_data_s[k];
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dir_block(input int k, input logic [127:0] ct, input int lat_exp,
                             input int st_idx, input int st_len, input int st0_len,
                             input int hold, input bit offer_next);
        int lat, nxt, s1, s0;
        bit seen;
        for (int i = 0; i < 50 && !in_ready_s[k]; i++) tick();
        chk(k, "wait_idle", in_ready_s[k], 1);
        in_valid_s[k] = 1; in_data_s[k] = ct; rk_valid_s[k] = 1; out_ready_s[k] = 0;
        tick();
        in_valid_s[k] = offer_next;
        lat = 0; nxt = 10 + 2 * k; s1 = st_len; s0 = st0_len; seen = 0;
        while (lat < 60 && !seen) begin
            rk_valid_s[k] = 1;
            if (rk_req_s[k]) begin
                if (int'(rk_idx_s[k]) == st_idx && s1 > 0) begin
                    rk_valid_s[k] = 0; s1--;
                end else if (rk_idx_s[k] == 4'd0 && s0 > 0) begin
                    rk_valid_s[k] = 0; s0--;
                end else begin
                    chk(k, "rk_idx_seq", rk_idx_s[k], nxt);
                    nxt--;
                end
            end
            tick();
            lat++;
            seen = out_valid_s[k];
        end
        rk_valid_s[k] = 1;
        chk(k, "rk_seq_end", nxt, -1);
        chk(k, "latency", lat, lat_exp);
        chk(k, "plaintext", out_data_s[k], PT);
        for (int h = 0; h < hold; h++) begin
            chk(k, "hold_out_valid", out_valid_s[k], 1);
            chk(k, "hold_out_data",  out_data_s[k],  PT);
            chk(k, "hold_in_ready",  in_ready_s[k],  0);
            tick();
        end
        out_ready_s[k] = 1;
        tick();
        out_ready_s[k] = 0;
        chk(k, "post_out_valid", out_valid_s[k], 0);
        chk(k, "post_in_ready",  in_ready_s[k],  1);
        chk(k, "post_out_data",  out_data_s[k],  PT);
    endtask

    // Start a block on engine 0 and run until rk_idx shows the target index.
    task automatic run_to_idx(input int target);
        int n;
        in_valid_s[0] = 1; in_data_s[0] = CT4; rk_valid_s[0] = 1;
        tick();
        in_valid_s[0] = 0;
        n = 0;
        while (n < 30 && !(rk_req_s[0] && int'(rk_idx_s[0]) == target)) begin
            tick(); n++;
        end
        chk(0, "reach_idx", rk_idx_s[0], target);
    endtask

    task automatic rand_drive(input int k, input int cycles);
        bit acc;
        int n;
        in_data_s[k] = {$urandom, $urandom, $urandom, $urandom};
        for (int c = 0; c < cycles; c++) begin
            if (!in_valid_s[k]) in_valid_s[k] = ($urandom_range(0, 2) == 0);
            rk_valid_s[k]  = ($urandom_range(0, 3) != 0);
            out_ready_s[k] = ($urandom_range(0, 2) != 0);
`ifdef AES_INV_ABORT_EN
            abort_s[k] = ($urandom_range(0, 63) == 0);
`endif
            acc = in_valid_s[k] && in_ready_s[k];
            tick();
            if (acc) begin
                in_data_s[k]  = {$urandom, $urandom, $urandom, $urandom};
                in_valid_s[k] = ($urandom_range(0, 1) == 0);
            end
        end
        in_valid_s[k] = 0; rk_valid_s[k] = 1; out_ready_s[k] = 1;
`ifdef AES_INV_ABORT_EN
        abort_s[k] = 0;
`endif
        n = 0;
        while (n < 40 && busy_s[k]) begin tick(); n++; end
        chk(k, "drain_idle", busy_s[k], 0);
        out_ready_s[k] = 0;
    endtask

    initial begin
        int d0, d1, d2;
        rst_n = 0;
        for (int k = 0; k < 3; k++) begin
            in_valid_s[k] = 0; in_data_s[k] = '0; rk_valid_s[k] = 0; out_ready_s[k] = 0;
            m_done[k] = 0;
`ifdef AES_INV_ABORT_EN
            abort_s[k] = 0;
`endif
        end
        build_sbox();
        expand(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0});
        expand(1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0});
        expand(2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);

        // literal pins for the model itself
        chk(0, "model_sbox00",    sbox[0],   8'h63);
        chk(0, "model_invsbox00", inv_sb[0], 8'h52);
        chk(0, "model_rk10",      rk_tab[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk(0, "model_fips128",   aes_dec(0, CT4), PT);
        chk(1, "model_fips192",   aes_dec(1, CT6), PT);
        chk(2, "model_fips256",   aes_dec(2, CT8), PT);

        repeat (3) tick();
        rst_n = 1;
        tick();

        dir_block(0, CT4, 11, -1, 0, 0, 0, 0);
        dir_block(0, CT4, 15,  5, 3, 1, 0, 0);
        dir_block(2, CT8, 15, -1, 0, 0, 0, 0);
        dir_block(1, CT6, 13, -1, 0, 0, 0, 0);
        // out_ready low 4 cycles; second block held during busy, taken in IDLE
        dir_block(0, CT4, 11, -1, 0, 0, 4, 1);
        dir_block(0, CT4, 11, -1, 0, 0, 0, 0);

        // reset in the middle of a block
        run_to_idx(6);
        rst_n = 0;
        #1;
        chk(0, "midrst_in_ready",  in_ready_s[0],  1);
        chk(0, "midrst_rk_req",    rk_req_s[0],    0);
        chk(0, "midrst_rk_idx",    rk_idx_s[0],    0);
        chk(0, "midrst_out_valid", out_valid_s[0], 0);
        chk(0, "midrst_out_data",  out_data_s[0],  0);
        chk(0, "midrst_busy",      busy_s[0],      0);
        tick(); tick();
        rst_n = 1;
        tick();
        dir_block(0, CT4, 11, -1, 0, 0, 0, 0);

`ifdef AES_INV_ABORT_EN
        run_to_idx(4);
        abort_s[0] = 1;
        tick();
        abort_s[0] = 0;
        chk(0, "abort_rk_req",    rk_req_s[0],    0);
        chk(0, "abort_out_valid", out_valid_s[0], 0);
        chk(0, "abort_in_ready",  in_ready_s[0],  1);
        tick();
        chk(0, "abort_no_out", out_valid_s[0], 0);
        dir_block(0, CT4, 11, -1, 0, 0, 0, 0);
`endif

        d0 = m_done[0]; d1 = m_done[1]; d2 = m_done[2];
        fork
            rand_drive(0, 1500);
            rand_drive(1, 1500);
            rand_drive(2, 1500);
        join
        chk(0, "rand_progress", (m_done[0] - d0) >= 5, 1);
        chk(1, "rand_progress", (m_done[1] - d1) >= 5, 1);
        chk(2, "rand_progress", (m_done[2] - d2) >= 5, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/aes_inv_round_ctrl.md
Name: aes_inv_round_ctrl

Overview:
- Iterative AES decryption engine: one inverse round per cycle through a single shared round datapath (InvShiftRows, InvSubBytes, AddRoundKey, InverseMixColumns).
- Fetches round keys from an external key store by index using a valid-handshake.
- Accepts ciphertext and returns plaintext with a valid/ready handshake.
- Sits between the key-expansion/key-store block and the system bus wrapper.

Parameters:
- NK, 4, key length in 32-bit words (4/6/8 → AES-128/192/256). NR = NK+6 is derived, not a parameter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ciphertext present
- in_ready  out  1  block can accept ciphertext (high only in IDLE)
- in_data  in  128  ciphertext; [127:120] = byte 0 (row0,col0), column-major FIPS-197 order
- rk_req  out  1  round key requested
- rk_idx  out  4  requested round-key index (NR..0)
- rk_valid  in  1  rk_data valid for rk_idx
- rk_data  in  128  round key, same byte order as in_data
- out_valid  out  1  plaintext valid
- out_ready  in  1  consumer accepts plaintext
- out_data  out  128  plaintext
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async assert, sync deassert use): state=IDLE, state register=0, round counter=0, in_ready=1, rk_req=0, rk_idx=0, out_valid=0, out_data=0, busy=0.
- Transfers: input on in_valid&&in_ready; key on rk_req&&rk_valid; output on out_valid&&out_ready.
- FSM:
  - IDLE: in_ready=1. On input transfer, latch in_data into the state register, set round=NR, go to INIT.
  - INIT: rk_req=1, rk_idx=NR. On key transfer, state ^= rk_data, round=NR-1, go to ROUND.
  - ROUND: rk_req=1, rk_idx=round. On key transfer, state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_data). If round==1 go to FINAL with round=0, else round decrements.
  - FINAL: rk_req=1, rk_idx=0. On key transfer, out_data = InvSubBytes(InvShiftRows(state)) ^ rk_data, out_valid=1, go to DONE.
  - DONE: hold out_data and out_valid until out_ready, then go to IDLE with out_valid=0 in the next cycle.
- Stall rules:
  - No state or counter change while rk_req=1 and rk_valid=0.
  - rk_idx is stable while rk_req=1.
  - rk_valid while rk_req=0 is ignored.
- Latency with rk_valid tied high: out_valid rises NR+1 cycles after the input-transfer edge (11 for NK=4, 13 for NK=6, 15 for NK=8). Each stalled key cycle adds exactly one cycle.
- Throughput: one block at a time. Because in_ready=0 outside IDLE, in_valid while busy is not accepted; the producer must hold it.
- DONE with out_ready already high: exits after exactly one out_valid cycle.
- out_data holds its last value after IDLE is re-entered, until the next FINAL key transfer.
- Reset mid-operation: immediate return to reset values; the partial block is discarded, and no out_valid pulse or rk_req occurs on the reset edge.
- Round counter is 4 bits; values outside NR..0 are unreachable. An illegal FSM encoding returns to IDLE.

Optional Feature:
- Macro: AES_INV_ABORT_EN.
- Defined: adds input abort (1 bit).
  - abort=1 in INIT, ROUND or FINAL: next cycle is IDLE, rk_req=0, state register cleared to 0, out_valid stays 0.
  - abort in IDLE or DONE: ignored; DONE completes normally.
  - abort takes priority over a simultaneous key transfer.
- Undefined: no abort port; the FSM is exactly as above.

Test Plan:
- NK=4, rk_valid=1 always, key 000102030405060708090a0b0c0d0e0f (bench expands keys), in_data 69c4e0d86a7b0430d8cdb78070b4c55a → out_data 00112233445566778899aabbccddeeff, out_valid exactly 11 cycles after input transfer, rk_idx sequence 10,9,…,0.
- Same vector with rk_valid deasserted for 3 cycles at rk_idx=5 and 1 cycle at rk_idx=0 → same plaintext, latency 15, rk_idx held stable during stalls.
- NK=8, key 000102…1f, in_data 8ea2b7ca516745bfeafc49904b496089 → out_data 00112233445566778899aabbccddeeff after 15 cycles; NK=6, key 000102…17, in_data dda97ca4864cdfe06eaf70a0ec0d7191 → same plaintext after 13 cycles.
- out_ready low for 4 cycles in DONE → out_valid and out_data stable all 4 cycles, in_ready=0; IDLE entered the cycle after the handshake. Second block offered during busy → not accepted until IDLE, then decrypts correctly.
- rst_n pulsed low at rk_idx=6 → all outputs at reset values immediately; fresh block afterwards decrypts correctly with latency 11.
- AES_INV_ABORT_EN: abort at rk_idx=4 → IDLE next cycle, no out_valid, rk_req=0; following block decrypts correctly.
